// File: rtl/checkpoint_recovery_ctrl.sv
// checkpoint_recovery_ctrl
// Branch checkpoint table with allocation, correct-path retirement and
// misprediction recovery sequencing (IDLE -> FLUSH -> RESTORE -> IDLE).
// Optional build macro: CKPT_PERF_CNT_EN adds saturating perf counters.
// `AL_SIZE (power of two) sets the active-list size; defaults to 32.

`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module checkpoint_recovery_ctrl #(
  parameter int DEPTH = 4,
  parameter int AL_W  = $clog2(`AL_SIZE),
  localparam int ID_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [AL_W-1:0]   alloc_al_idx,
  output logic              alloc_ready,
  output logic [ID_W-1:0]   alloc_id,
  input  logic              resolve_valid,
  input  logic [ID_W-1:0]   resolve_id,
  input  logic              resolve_mispredict,
  output logic              resolve_ready,
  input  logic [AL_W-1:0]   al_back,
  output logic              recover_valid,
  output logic [AL_W-1:0]   recover_front,
  output logic [DEPTH-1:0]  flush_mask,
  output logic              restore_req,
  output logic [ID_W-1:0]   restore_id,
  input  logic              restore_ack,
  output logic              dispatch_stall,
  output logic [DEPTH-1:0]  ckpt_valid
`ifdef CKPT_PERF_CNT_EN
  ,
  output logic [31:0]       perf_recoveries,
  output logic [31:0]       perf_alloc_stall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  // Distance from the oldest AL entry; wraps naturally in AL_W bits.
  function automatic logic [AL_W-1:0] age_f(input logic [AL_W-1:0] x,
                                            input logic [AL_W-1:0] back);
    return x - back;
  endfunction

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [AL_W-1:0]     idx_q [DEPTH];
  logic [AL_W-1:0]     idx_d [DEPTH];
  logic [ID_W-1:0]     fault_id_q, fault_id_d;
  logic [AL_W-1:0]     b_idx_q, b_idx_d;
  logic                recover_valid_q, recover_valid_d;
  logic [AL_W-1:0]     recover_front_q, recover_front_d;
  logic                restore_req_q, restore_req_d;
  logic [ID_W-1:0]     restore_id_q, restore_id_d;

  logic                idle_s;
  logic                any_free_s;
  logic [ID_W-1:0]     alloc_id_s;
  logic                res_hit_s;
  logic                mispredict_s;
  logic                alloc_ready_s;
  logic                alloc_fire_s;
  logic [DEPTH-1:0]    flush_mask_s;

  // Request decode from registered state: free-entry search, resolve hit, handshakes.
  always_comb begin
    idle_s       = (state_q == ST_IDLE);
    any_free_s   = ~(&valid_q);
    alloc_id_s   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alloc_id_s = (!valid_q[i]) ? ID_W'(i) : alloc_id_s;
    end
    res_hit_s     = idle_s && resolve_valid && valid_q[resolve_id];
    mispredict_s  = res_hit_s && resolve_mispredict;
    alloc_ready_s = idle_s && any_free_s && !mispredict_s;
    alloc_fire_s  = alloc_valid && alloc_ready_s;
  end

  // Entries strictly younger than the faulting branch, only meaningful in FLUSH.
  always_comb begin
    flush_mask_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush_mask_s[i] = (state_q == ST_FLUSH) && valid_q[i] &&
                        (age_f(idx_q[i], al_back) > age_f(b_idx_q, al_back));
    end
  end

  // Next-state computation for the table and the recovery sequencer.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    idx_d           = idx_q;
    fault_id_d      = fault_id_q;
    b_idx_d         = b_idx_q;
    recover_valid_d = 1'b0;
    recover_front_d = '0;
    restore_req_d   = restore_req_q;
    restore_id_d    = restore_id_q;
    case (state_q)
      ST_IDLE: begin
        if (alloc_fire_s) begin
          valid_d[alloc_id_s] = 1'b1;
          idx_d[alloc_id_s]   = alloc_al_idx;
        end else begin
          valid_d = valid_d;
        end
        if (mispredict_s) begin
          fault_id_d      = resolve_id;
          b_idx_d         = idx_q[resolve_id];
          recover_valid_d = 1'b1;
          recover_front_d = idx_q[resolve_id] + {{(AL_W-1){1'b0}}, 1'b1};
          state_d         = ST_FLUSH;
        end else if (res_hit_s) begin
          valid_d[resolve_id] = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // Faulting entry survives so the rename map can restore from it.
        valid_d       = valid_q & ~flush_mask_s;
        restore_req_d = 1'b1;
        restore_id_d  = fault_id_q;
        state_d       = ST_RESTORE;
      end
      ST_RESTORE: begin
        if (restore_ack) begin
          valid_d[fault_id_q] = 1'b0;
          restore_req_d       = 1'b0;
          restore_id_d        = '0;
          state_d             = ST_IDLE;
        end else begin
          state_d = ST_RESTORE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        restore_req_d = 1'b0;
        restore_id_d  = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      valid_q         <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
      end
      fault_id_q      <= '0;
      b_idx_q         <= '0;
      recover_valid_q <= 1'b0;
      recover_front_q <= '0;
      restore_req_q   <= 1'b0;
      restore_id_q    <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      idx_q           <= idx_d;
      fault_id_q      <= fault_id_d;
      b_idx_q         <= b_idx_d;
      recover_valid_q <= recover_valid_d;
      recover_front_q <= recover_front_d;
      restore_req_q   <= restore_req_d;
      restore_id_q    <= restore_id_d;
    end
  end

  assign alloc_ready    = alloc_ready_s;
  assign alloc_id       = alloc_id_s;
  assign resolve_ready  = idle_s;
  assign recover_valid  = recover_valid_q;
  assign recover_front  = recover_front_q;
  assign flush_mask     = flush_mask_s;
  assign restore_req    = restore_req_q;
  assign restore_id     = restore_id_q;
  assign dispatch_stall = !idle_s || mispredict_s;
  assign ckpt_valid     = valid_q;

`ifdef CKPT_PERF_CNT_EN
  logic [31:0] perf_rec_q, perf_rec_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating event counters for recoveries and stalled allocation requests.
  always_comb begin
    if ((state_q == ST_FLUSH) && (perf_rec_q != 32'hFFFF_FFFF)) begin
      perf_rec_d = perf_rec_q + 32'd1;
    end else begin
      perf_rec_d = perf_rec_q;
    end
    if (alloc_valid && !alloc_ready_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rec_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_rec_q   <= perf_rec_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_recoveries  = perf_rec_q;
  assign perf_alloc_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
// Testbench for checkpoint_recovery_ctrl: directed test-plan steps followed
// by randomized traffic, all checked against a behavioural table model.

`ifndef AL_SIZE
`define AL_SIZE 32
`endif

module tb_checkpoint_recovery_ctrl;

  localparam int DEPTH = 4;
  localparam int ALS   = `AL_SIZE;
  localparam int AL_W  = $clog2(ALS);
  localparam int ID_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alloc_valid = 1'b0;
  logic [AL_W-1:0]   alloc_al_idx = '0;
  logic              alloc_ready;
  logic [ID_W-1:0]   alloc_id;
  logic              resolve_valid = 1'b0;
  logic [ID_W-1:0]   resolve_id = '0;
  logic              resolve_mispredict = 1'b0;
  logic              resolve_ready;
  logic [AL_W-1:0]   al_back = '0;
  logic              recover_valid;
  logic [AL_W-1:0]   recover_front;
  logic [DEPTH-1:0]  flush_mask;
  logic              restore_req;
  logic [ID_W-1:0]   restore_id;
  logic              restore_ack = 1'b0;
  logic              dispatch_stall;
  logic [DEPTH-1:0]  ckpt_valid;
`ifdef CKPT_PERF_CNT_EN
  logic [31:0]       perf_recoveries;
  logic [31:0]       perf_alloc_stall;
`endif

  checkpoint_recovery_ctrl #(.DEPTH(DEPTH), .AL_W(AL_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_al_idx(alloc_al_idx),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id),
    .resolve_mispredict(resolve_mispredict), .resolve_ready(resolve_ready),
    .al_back(al_back),
    .recover_valid(recover_valid), .recover_front(recover_front),
    .flush_mask(flush_mask),
    .restore_req(restore_req), .restore_id(restore_id),
    .restore_ack(restore_ack),
    .dispatch_stall(dispatch_stall), .ckpt_valid(ckpt_valid)
`ifdef CKPT_PERF_CNT_EN
    , .perf_recoveries(perf_recoveries), .perf_alloc_stall(perf_alloc_stall)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: which checkpoints are live and the AL index each holds.
  bit m_valid [DEPTH];
  int m_idx   [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic int age(input int x, input int back);
    return (((x - back) % ALS) + ALS) % ALS;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < DEPTH; i++) v[i] = m_valid[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid        = 1'b0;
    resolve_valid      = 1'b0;
    resolve_mispredict = 1'b0;
    restore_ack        = 1'b0;
  endtask

  // Walk FLUSH and RESTORE after an accepted mispredict on checkpoint fid.
  task automatic recovery(input int fid, input int ack_delay, input bit rst_mid);
    int b;
    int back;
    logic [31:0] exp_mask;
    b = m_idx[fid];
    back = int'(al_back);
    exp_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mask[i] = m_valid[i] && (age(m_idx[i], back) > age(b, back));
    end
    check("flush.recover_valid", 32'(recover_valid), 32'd1);
    check("flush.recover_front", 32'(recover_front), 32'((b + 1) % ALS));
    check("flush.flush_mask", 32'(flush_mask), exp_mask);
    check("flush.dispatch_stall", 32'(dispatch_stall), 32'd1);
    check("flush.restore_req", 32'(restore_req), 32'd0);
    check("flush.resolve_ready", 32'(resolve_ready), 32'd0);
    restore_ack = 1'b1;   // outside RESTORE, must be ignored
    alloc_valid = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_mask[i]) m_valid[i] = 1'b0;
    end
    check("restore.recover_valid", 32'(recover_valid), 32'd0);
    check("restore.restore_req", 32'(restore_req), 32'd1);
    check("restore.restore_id", 32'(restore_id), 32'(fid));
    check("restore.ckpt_valid", 32'(ckpt_valid), model_vec());
    for (int d = 0; d < ack_delay; d++) begin
      alloc_valid        = 1'b1;
      alloc_al_idx       = AL_W'($urandom_range(ALS - 1, 0));
      resolve_valid      = 1'b1;
      resolve_id         = ID_W'($urandom_range(DEPTH - 1, 0));
      resolve_mispredict = 1'($urandom_range(1, 0));
      #3;
      check("wait.restore_req", 32'(restore_req), 32'd1);
      check("wait.dispatch_stall", 32'(dispatch_stall), 32'd1);
      check("wait.resolve_ready", 32'(resolve_ready), 32'd0);
      check("wait.alloc_ready", 32'(alloc_ready), 32'd0);
      step();
      check("wait.ckpt_valid", 32'(ckpt_valid), model_vec());
    end
    clear_inputs();
    if (rst_mid) begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      check("rst.ckpt_valid", 32'(ckpt_valid), 32'd0);
      check("rst.recover_valid", 32'(recover_valid), 32'd0);
      check("rst.restore_req", 32'(restore_req), 32'd0);
      check("rst.restore_id", 32'(restore_id), 32'd0);
      check("rst.dispatch_stall", 32'(dispatch_stall), 32'd0);
      check("rst.flush_mask", 32'(flush_mask), 32'd0);
      check("rst.alloc_ready", 32'(alloc_ready), 32'd1);
    end else begin
      restore_ack = 1'b1;
      #3;
      check("ack.restore_req_before", 32'(restore_req), 32'd1);
      step();
      restore_ack = 1'b0;
      m_valid[fid] = 1'b0;
      check("ack.restore_req_after", 32'(restore_req), 32'd0);
      check("ack.dispatch_stall", 32'(dispatch_stall), 32'd0);
      check("ack.resolve_ready", 32'(resolve_ready), 32'd1);
      check("ack.ckpt_valid", 32'(ckpt_valid), model_vec());
    end
  endtask

  // One IDLE cycle with optional alloc and resolve; runs recovery if a mispredict hits.
  task automatic drive_cycle(input bit av, input int aidx, input bit rv, input int rid,
                             input bit rmis, input int ack_delay, input bit rst_mid);
    bit hit;
    bit mis;
    int lf;
    bit exp_ready;
    hit = rv && m_valid[rid];
    mis = hit && rmis;
    lf  = lowest_free();
    exp_ready = (lf >= 0) && !mis;
    alloc_valid        = av;
    alloc_al_idx       = AL_W'(aidx);
    resolve_valid      = rv;
    resolve_id         = ID_W'(rid);
    resolve_mispredict = rmis;
    restore_ack        = 1'($urandom_range(1, 0));  // ignored in IDLE
    #3;
    check("idle.alloc_ready", 32'(alloc_ready), 32'(exp_ready));
    if (exp_ready) check("idle.alloc_id", 32'(alloc_id), 32'(lf));
    check("idle.dispatch_stall", 32'(dispatch_stall), 32'(mis));
    check("idle.resolve_ready", 32'(resolve_ready), 32'd1);
    step();
    clear_inputs();
    if (av && exp_ready) begin
      m_valid[lf] = 1'b1;
      m_idx[lf]   = aidx;
    end
    if (hit && !rmis) m_valid[rid] = 1'b0;
    check("idle.ckpt_valid", 32'(ckpt_valid), model_vec());
    if (mis) recovery(rid, ack_delay, rst_mid);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_idx[i]   = 0;
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset.ckpt_valid", 32'(ckpt_valid), 32'd0);
    check("reset.recover_valid", 32'(recover_valid), 32'd0);
    check("reset.restore_req", 32'(restore_req), 32'd0);
    check("reset.dispatch_stall", 32'(dispatch_stall), 32'd0);
    check("reset.flush_mask", 32'(flush_mask), 32'd0);
    check("reset.alloc_ready", 32'(alloc_ready), 32'd1);

    // Fill the table, then a fifth request must be refused.
    al_back = AL_W'(2);
    drive_cycle(1'b1, 3,  1'b0, 0, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 5,  1'b0, 0, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 9,  1'b0, 0, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 12, 1'b0, 0, 1'b0, 0, 1'b0);
    check("fill.ckpt_valid", 32'(ckpt_valid), 32'hF);
    drive_cycle(1'b1, 20, 1'b0, 0, 1'b0, 0, 1'b0);

    // Resolve and alloc together on a full table: grant only next cycle.
    drive_cycle(1'b1, 5, 1'b1, 1, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0);
    check("regrant.ckpt_valid", 32'(ckpt_valid), 32'hF);

    // Mispredict without wrap, immediate ack.
    drive_cycle(1'b1, 7, 1'b1, 1, 1'b1, 0, 1'b0);
    check("nowrap.ckpt_valid", 32'(ckpt_valid), 32'h1);

    // Mispredict across the AL wrap, ack delayed 5 cycles.
    drive_cycle(1'b0, 0, 1'b1, 0, 1'b0, 0, 1'b0);
    al_back = AL_W'(28);
    drive_cycle(1'b1, 29, 1'b0, 0, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 31, 1'b0, 0, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 1,  1'b0, 0, 1'b0, 0, 1'b0);
    drive_cycle(1'b1, 4,  1'b0, 0, 1'b0, 0, 1'b0);
    drive_cycle(1'b0, 0, 1'b1, 1, 1'b1, 5, 1'b0);
    check("wrap.ckpt_valid", 32'(ckpt_valid), 32'h1);

    // Reset in the middle of RESTORE, then allocation restarts at id 0.
    drive_cycle(1'b0, 0, 1'b1, 0, 1'b1, 2, 1'b1);
    drive_cycle(1'b1, 11, 1'b0, 0, 1'b0, 0, 1'b0);
    check("post_rst.ckpt_valid", 32'(ckpt_valid), 32'h1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      al_back = AL_W'($urandom_range(ALS - 1, 0));
      drive_cycle(1'($urandom_range(1, 0)), int'($urandom_range(ALS - 1, 0)),
                  1'($urandom_range(1, 0)), int'($urandom_range(DEPTH - 1, 0)),
                  ($urandom_range(5, 0) == 0), int'($urandom_range(3, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
